// File: rtl/ext_mem_model_nch.sv
// N-channel off-chip byte-array memory slave for HLS top-level benches.
// Per-channel delayed DataRdy, little-endian multi-byte access, sticky errors and activity counters.
module ext_mem_model_nch #(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int MEM_BYTES = 1,
    parameter int BASE_ADDR = 0,
    parameter int RD_DELAY  = 2,
    parameter int WR_DELAY  = 1,
    parameter int SIZE_W    = $clog2(DATA_W) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_CH-1:0]        oe_ram,
    input  logic [N_CH-1:0]        we_ram,
    input  logic [N_CH*ADDR_W-1:0] addr_ram,
    input  logic [N_CH*DATA_W-1:0] Wdata_ram,
    input  logic [N_CH*SIZE_W-1:0] data_ram_size,
    input  logic                   ld_en,
    input  logic [ADDR_W-1:0]      ld_addr,
    input  logic [7:0]             ld_data,
    output logic [N_CH*DATA_W-1:0] Rdata_ram,
    output logic [N_CH-1:0]        DataRdy,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [31:0]            access_cnt,
    output logic [15:0]            collision_cnt
);
    localparam int LANES = DATA_W / 8;

    logic [7:0]      mem [MEM_BYTES];
    logic [31:0]     cnt [N_CH];

    int              off [N_CH];
    int              nbytes [N_CH];
    logic [N_CH-1:0] claim;
    logic [N_CH-1:0] bad_rw;
    logic [N_CH-1:0] bad_size;
    logic [N_CH-1:0] bad_range;
    logic [N_CH-1:0] ch_err;
    logic [N_CH-1:0] wr_en;
    logic [31:0]     rdy_sum;
    logic            any_err;
    logic [1:0]      first_code;

    logic [7:0]      byte_nxt [MEM_BYTES];
    logic [MEM_BYTES-1:0] byte_we;
    logic            collide;
    int              hits;

    function automatic logic covers(input int o, input int nb, input int j);
        return (j >= o) && (j < o + nb);
    endfunction

    function automatic logic [1:0] code_of(input logic rw, input logic sz);
        if (rw)      return 2'd1;
        else if (sz) return 2'd3;
        else         return 2'd2;
    endfunction

    // Claim is decided by the base address alone so a span overrunning the top is still answered (with an error).
    always_comb begin
        rdy_sum    = '0;
        any_err    = 1'b0;
        first_code = 2'd0;
        for (int i = 0; i < N_CH; i++) begin
            off[i]       = int'(addr_ram[i*ADDR_W +: ADDR_W]) - BASE_ADDR;
            nbytes[i]    = int'(data_ram_size[i*SIZE_W +: SIZE_W]) / 8;
            claim[i]     = (oe_ram[i] | we_ram[i]) && (off[i] >= 0) && (off[i] < MEM_BYTES);
            bad_rw[i]    = oe_ram[i] & we_ram[i];
            bad_size[i]  = (data_ram_size[i*SIZE_W +: SIZE_W] == '0)
                        || (int'(data_ram_size[i*SIZE_W +: SIZE_W]) > DATA_W)
                        || (data_ram_size[i*SIZE_W +: 3] != 3'd0);
            bad_range[i] = (off[i] + nbytes[i]) > MEM_BYTES;
            ch_err[i]    = bad_rw[i] | bad_size[i] | bad_range[i];
            DataRdy[i]   = reset && claim[i]
                        && (cnt[i] == 32'(oe_ram[i] ? RD_DELAY - 1 : WR_DELAY - 1));
            wr_en[i]     = DataRdy[i] && we_ram[i] && !ch_err[i];
            rdy_sum      = rdy_sum + 32'(DataRdy[i]);
        end
        // Descending scan leaves the lowest erroring channel's code.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (claim[i] && ch_err[i]) begin
                any_err    = 1'b1;
                first_code = code_of(bad_rw[i], bad_size[i]);
            end
        end
    end

    always_comb begin
        Rdata_ram = '0;
        for (int i = 0; i < N_CH; i++) begin
            for (int b = 0; b < LANES; b++) begin
                for (int j = 0; j < MEM_BYTES; j++) begin
                    if (DataRdy[i] && oe_ram[i] && !ch_err[i] && (b < nbytes[i]) && (off[i] + b == j))
                        Rdata_ram[(i*LANES + b)*8 +: 8] = mem[j];
                end
            end
        end
    end

    // Later writers override earlier ones: preload first, then channels in ascending index.
    always_comb begin
        byte_we = '0;
        collide = 1'b0;
        hits    = 0;
        for (int j = 0; j < MEM_BYTES; j++) begin
            byte_nxt[j] = ld_data;
            hits        = 0;
            if (ld_en && (int'(ld_addr) - BASE_ADDR == j))
                byte_we[j] = 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en[i] && covers(off[i], nbytes[i], j)) begin
                    byte_we[j]  = 1'b1;
                    byte_nxt[j] = Wdata_ram[i*DATA_W + (j - off[i])*8 +: 8];
                    hits        = hits + 1;
                end
            end
            if (hits > 1)
                collide = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        for (int j = 0; j < MEM_BYTES; j++) begin
            if (byte_we[j])
                mem[j] <= byte_nxt[j];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= '0;
            err           <= 1'b0;
            err_code      <= 2'd0;
            access_cnt    <= '0;
            collision_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!claim[i] || DataRdy[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 32'd1;
            end
            if (any_err && !err) begin
                err      <= 1'b1;
                err_code <= first_code;
            end
            access_cnt <= access_cnt + rdy_sum;
            if (collide && (collision_cnt != 16'hFFFF))
                collision_cnt <= collision_cnt + 16'd1;
        end
    end
endmodule
